ex_div_seq: RTL and testbench

- Multi-cycle sequencer for 32-bit signed/unsigned division (MIPS DIV/DIVU) attached to the EX stage.
- Latches operands on start and runs a radix-2 restoring divide, one bit per cycle.
- Holds the pipeline via stall_req_o until the result is ready, then presents {remainder, quotient} for HI/LO writeback.
- Aborts cleanly when the EX instruction is annulled (flush or exception).

---
 rtl/ex_div_seq.sv | 104 ++++++++++
 tb/tb_ex_div_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Holds the pipeline until {remainder, quotient} is ready for HI/LO writeback.
module ex_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_req_o
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;   // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             sgn_a, sgn_b;

    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             trial_unused;
    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

    assign last_step = (cnt == CNT_W'(WIDTH));

    // Shifted partial remainder can need WIDTH+1 bits; one extra bit exposes the borrow.
    assign shifted      = {rem, dvd[WIDTH-1]};
    assign trial        = {1'b0, shifted} - {2'b00, dvs};
    assign borrow       = trial[WIDTH+1];
    assign trial_unused = trial[WIDTH];

    assign a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign q_fix = (sgn_a ^ sgn_b) ? -dvd : dvd;
    assign r_fix = sgn_a ? -rem : rem;

    assign stall_req_o = start_i & ~annul_i & ~ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_i && !annul_i)
                          state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
            S_BYZERO: state_nxt = annul_i ? S_IDLE : S_END;
            S_ON:     if (annul_i)        state_nxt = S_IDLE;
                      else if (last_step) state_nxt = S_END;
            S_END:    if (annul_i || !start_i) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            sgn_a    <= 1'b0;
            sgn_b    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= (state_nxt == S_END);
            case (state)
                S_IDLE: if (start_i && !annul_i && opdata2_i != '0) begin
                    dvd   <= a_abs;
                    dvs   <= b_abs;
                    sgn_a <= signed_div_i & opdata1_i[WIDTH-1];
                    sgn_b <= signed_div_i & opdata2_i[WIDTH-1];
                    rem   <= '0;
                    cnt   <= '0;
                end
                S_BYZERO: if (!annul_i) result_o <= '0;
                S_ON: if (!annul_i) begin
                    if (last_step) begin
                        result_o <= {r_fix, q_fix};
                    end else begin
                        rem <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], ~borrow};
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_seq.sv
// Randomized bench for ex_div_seq: a cycle-count/arithmetic model drives a per-cycle
// compare, with directed divides pinning latency and hand-computed results.
module tb_ex_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int checks = 0;
    int errors = 0;

    ex_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o), .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference divide in 64-bit arithmetic so signed overflow wraps naturally.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural model: cycles remaining until the result appears, plus expected outputs.
    int          m_remain = 0;
    logic        m_ready = 1'b0;
    logic [63:0] m_res = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_remain = 0;
            m_ready  = 1'b0;
            m_res    = '0;
        end else if (m_ready) begin
            if (annul_i || !start_i) m_ready = 1'b0;
        end else if (m_remain > 0) begin
            if (annul_i) m_remain = 0;
            else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_ready = 1'b1;
                    m_res   = m_pend;
                end
            end
        end else if (start_i && !annul_i) begin
            m_remain = (opdata2_i == 0) ? 1 : 33;
            m_pend   = ref_div(signed_div_i, opdata1_i, opdata2_i);
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_ready", {63'd0, ready_o}, {63'd0, m_ready});
            chk("cyc_stall", {63'd0, stall_req_o}, {63'd0, start_i & ~annul_i & ~m_ready});
            chk("cyc_result", result_o, m_res);
        end
    end

    task automatic drv_slot();
        @(negedge clk);
        #1;
    endtask

    task automatic do_div(input string name, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        drv_slot();
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        chk({name, "_stall0"}, {63'd0, stall_req_o}, 64'd1);
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) got = 1'b1;
        end
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_res"}, result_o, exp);
        chk({name, "_stall_end"}, {63'd0, stall_req_o}, 64'd0);
        drv_slot();
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_drop"}, {63'd0, ready_o}, 64'd0);
    endtask

    task automatic rand_div();
        bit  do_annul;
        int  k, hold;
        bit  done;
        logic [31:0] b;
        case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
        endcase
        drv_slot();
        signed_div_i = $urandom_range(0, 1);
        opdata1_i    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        opdata2_i    = b;
        start_i      = 1'b1;
        do_annul     = ($urandom_range(0, 7) == 0);
        k            = $urandom_range(0, 36);
        hold         = $urandom_range(0, 2);
        done         = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            drv_slot();
            if (do_annul && c == k) begin
                annul_i = 1'b1;
                start_i = 1'b0;
                drv_slot();
                annul_i = 1'b0;
                done    = 1'b1;
            end else if (ready_o) begin
                repeat (hold) drv_slot();
                start_i = 1'b0;
                done    = 1'b1;
            end
        end
        if (!done) chk("rand_timeout", 64'd0, 64'd1);
        start_i = 1'b0;
        drv_slot();
    endtask

    initial begin
        // Hand-computed pins on the reference itself.
        chk("ref_divu_7_2",  ref_div(0, 32'd7, 32'd2), {32'd1, 32'd3});
        chk("ref_div_m7_2",  ref_div(1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("ref_div_7_m2",  ref_div(1, 32'd7, 32'hFFFF_FFFE), {32'd1, 32'hFFFF_FFFD});
        chk("ref_div_ovf",   ref_div(1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
        chk("ref_divu_100_7", ref_div(0, 32'd100, 32'd7), {32'd2, 32'd14});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_stall", {63'd0, stall_req_o}, 64'd0);
        drv_slot();
        rst = 1'b1;
        cmp_en = 1'b1;
        drv_slot();

        do_div("divu_7_2",   0, 32'd7, 32'd2, {32'd1, 32'd3}, 34);
        do_div("div_m7_2",   1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        do_div("div_7_m2",   1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34);
        do_div("divu_5_0",   0, 32'd5, 32'd0, 64'd0, 2);
        do_div("div_ovf",    1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34);
        do_div("divu_max_1", 0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34);
        do_div("divu_big",   0, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'd1}, 34);

        // Annul mid-divide: result keeps the previous value, ready never rises.
        drv_slot();
        signed_div_i = 1'b0;
        opdata1_i    = 32'd9;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) drv_slot();
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        chk("annul_keep", result_o, {32'h7FFF_FFFE, 32'd1});
        drv_slot();
        annul_i = 1'b0;
        repeat (3) drv_slot();
        do_div("divu_100_7", 0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

        // Asynchronous reset in the middle of a divide.
        drv_slot();
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        chk("arst_ready", {63'd0, ready_o}, 64'd0);
        chk("arst_result", result_o, 64'd0);
        chk("arst_stall", {63'd0, stall_req_o}, 64'd0);
        repeat (2) drv_slot();
        rst = 1'b1;
        drv_slot();
        do_div("post_rst", 1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34);

        for (int i = 0; i < 150; i++) rand_div();

        repeat (2) drv_slot();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
